// File: rtl/fetch_unit.sv
// Instruction fetch stage with IF/ID register and a one-entry skid buffer.
// Latency: one cycle from imem_ack to instruction/valid; one instruction every 2 cycles with 1-cycle memory.
// Backpressure: freeze holds IF/ID; a fetch returning under freeze parks in the skid and fetching pauses until it drains.
module fetch_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  freeze,
    input  logic                  branch_taken,
    input  logic [ADDR_WIDTH-1:0] branch_addr,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_ack,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic [ADDR_WIDTH-1:0] pc_out,
    output logic [DATA_WIDTH-1:0] instruction,
    output logic                  valid
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
    logic                    req_q, req_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [ADDR_WIDTH-1:0]   out_pc_q, out_pc_d;
    logic [DATA_WIDTH-1:0]   out_dat_q, out_dat_d;
    logic                    out_vld_q, out_vld_d;
    logic                    skid_vld_q, skid_vld_d;
    logic [DATA_WIDTH-1:0]   skid_dat_q, skid_dat_d;
    logic [ADDR_WIDTH-1:0]   skid_pc_q, skid_pc_d;

    logic [ADDR_WIDTH-1:0]   pc_plus4;
    logic [ADDR_WIDTH-1:0]   br_tgt;
    logic                    unused_br_low;

    assign pc_plus4      = pc_q + ADDR_WIDTH'(4);
    assign br_tgt        = {branch_addr[ADDR_WIDTH-1:2], 2'b00};
    assign unused_br_low = ^branch_addr[1:0];

    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign pc_out      = out_pc_q;
    assign instruction = out_dat_q;
    assign valid       = out_vld_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            req_q      <= 1'b0;
            addr_q     <= '0;
            out_pc_q   <= '0;
            out_dat_q  <= '0;
            out_vld_q  <= 1'b0;
            skid_vld_q <= 1'b0;
            skid_dat_q <= '0;
            skid_pc_q  <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            out_pc_q   <= out_pc_d;
            out_dat_q  <= out_dat_d;
            out_vld_q  <= out_vld_d;
            skid_vld_q <= skid_vld_d;
            skid_dat_q <= skid_dat_d;
            skid_pc_q  <= skid_pc_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_d      = req_q;
        addr_d     = addr_q;
        out_pc_d   = out_pc_q;
        out_dat_d  = out_dat_q;
        out_vld_d  = out_vld_q;
        skid_vld_d = skid_vld_q;
        skid_dat_d = skid_dat_q;
        skid_pc_d  = skid_pc_q;

        if (branch_taken) begin
            // Flush wins over freeze and ack; an in-flight request must still complete, so it goes to DROP.
            pc_d       = br_tgt;
            out_vld_d  = 1'b0;
            out_dat_d  = '0;
            out_pc_d   = '0;
            skid_vld_d = 1'b0;
            case (state_q)
                S_WAIT: begin
                    if (imem_ack) begin
                        state_d = S_IDLE;
                        req_d   = 1'b0;
                    end else begin
                        state_d = S_DROP;
                    end
                end
                S_DROP: begin
                    if (imem_ack) begin
                        state_d = S_IDLE;
                        req_d   = 1'b0;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    req_d   = 1'b0;
                end
            endcase
        end else begin
            if (!freeze) begin
                if (skid_vld_q) begin
                    out_dat_d  = skid_dat_q;
                    out_pc_d   = skid_pc_q;
                    out_vld_d  = 1'b1;
                    skid_vld_d = 1'b0;
                end else begin
                    out_vld_d  = 1'b0;
                end
            end

            case (state_q)
                S_IDLE: begin
                    if (!skid_vld_q) begin
                        state_d = S_WAIT;
                        req_d   = 1'b1;
                        addr_d  = pc_q;
                    end
                end
                S_WAIT: begin
                    if (imem_ack) begin
                        pc_d = pc_plus4;
                        if (!freeze || !out_vld_q) begin
                            out_dat_d = imem_rdata;
                            out_pc_d  = pc_plus4;
                            out_vld_d = 1'b1;
                            addr_d    = pc_plus4;
                        end else begin
                            // ID is stalled on a live instruction: park this one and stop fetching.
                            skid_vld_d = 1'b1;
                            skid_dat_d = imem_rdata;
                            skid_pc_d  = pc_plus4;
                            state_d    = S_IDLE;
                            req_d      = 1'b0;
                        end
                    end
                end
                S_DROP: begin
                    if (imem_ack) begin
                        state_d = S_IDLE;
                        req_d   = 1'b0;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    req_d   = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a randomized run against a transaction-level model.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] pc_out;
    logic [31:0] instruction;
    logic        valid;

    int total = 0;
    int bad   = 0;

    fetch_unit #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .RESET_PC  (32'h0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .freeze      (freeze),
        .branch_taken(branch_taken),
        .branch_addr (branch_addr),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .pc_out      (pc_out),
        .instruction (instruction),
        .valid       (valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b0; freeze = 1'b0; branch_taken = 1'b0; branch_addr = '0;
        imem_ack = 1'b0; imem_rdata = '0;
        step; step;
        rst = 1'b1;
    endtask

    // Called in the first cycle a request is visible; acks in the following cycle.
    task automatic fetch(input logic [31:0] d);
        step;
        imem_ack = 1'b1; imem_rdata = d;
        step;
        imem_ack = 1'b0; imem_rdata = '0;
    endtask

    task automatic test_reset;
        rst = 1'b0; freeze = 1'b0; branch_taken = 1'b0; branch_addr = '0;
        imem_ack = 1'b0; imem_rdata = '0;
        step; step;
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%0h want=0", imem_req); end
        total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL rst_addr got=%h want=0", imem_addr); end
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0h want=0", valid); end
        total++; if (pc_out !== 32'h0) begin bad++; $display("FAIL rst_pc_out got=%h want=0", pc_out); end
        total++; if (instruction !== 32'h0) begin bad++; $display("FAIL rst_instr got=%h want=0", instruction); end
    endtask

    task automatic test_first_fetch;
        do_reset;
        step;
        total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL ff_req got=%0h want=1", imem_req); end
        total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL ff_addr got=%h want=0", imem_addr); end
        fetch(32'hE1234567);
        total++; if (valid !== 1'b1) begin bad++; $display("FAIL ff_valid got=%0h want=1", valid); end
        total++; if (instruction !== 32'hE1234567) begin bad++; $display("FAIL ff_instr got=%h want=e1234567", instruction); end
        total++; if (pc_out !== 32'h4) begin bad++; $display("FAIL ff_pc_out got=%h want=4", pc_out); end
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin bad++; $display("FAIL ff_next_req got=%0h/%h want=1/4", imem_req, imem_addr); end
    endtask

    task automatic test_latency;
        do_reset;
        step;
        for (int i = 0; i < 3; i++) begin
            total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin bad++; $display("FAIL lat_hold%0d got=%0h/%h want=1/0", i, imem_req, imem_addr); end
            total++; if (valid !== 1'b0) begin bad++; $display("FAIL lat_novalid%0d got=%0h want=0", i, valid); end
            if (i == 2) begin imem_ack = 1'b1; imem_rdata = 32'hE3A01005; end
            step;
        end
        imem_ack = 1'b0; imem_rdata = '0;
        total++; if (valid !== 1'b1 || instruction !== 32'hE3A01005) begin bad++; $display("FAIL lat_capture got=%0h/%h want=1/e3a01005", valid, instruction); end
        total++; if (pc_out !== 32'h4 || imem_addr !== 32'h4) begin bad++; $display("FAIL lat_pc got=%h/%h want=4/4", pc_out, imem_addr); end
        step;
        total++; if (valid !== 1'b0 || instruction !== 32'hE3A01005) begin bad++; $display("FAIL lat_gap got=%0h/%h want=0/e3a01005", valid, instruction); end
    endtask

    task automatic test_freeze;
        do_reset;
        step;
        fetch(32'h11110000);
        fetch(32'h22220004);
        freeze = 1'b1;
        step;
        imem_ack = 1'b1; imem_rdata = 32'h33330008;
        step;
        imem_ack = 1'b0; imem_rdata = '0;
        for (int i = 0; i < 3; i++) begin
            total++; if (valid !== 1'b1 || instruction !== 32'h22220004 || pc_out !== 32'h8) begin bad++; $display("FAIL frz_hold%0d got=%0h/%h/%h want=1/22220004/8", i, valid, instruction, pc_out); end
            total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL frz_noreq%0d got=%0h want=0", i, imem_req); end
            if (i < 2) step;
        end
        freeze = 1'b0;
        step;
        total++; if (valid !== 1'b1 || instruction !== 32'h33330008 || pc_out !== 32'hC) begin bad++; $display("FAIL frz_skid got=%0h/%h/%h want=1/33330008/c", valid, instruction, pc_out); end
        step;
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin bad++; $display("FAIL frz_next_req got=%0h/%h want=1/c", imem_req, imem_addr); end
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL frz_drain got=%0h want=0", valid); end
    endtask

    task automatic test_branch_wait;
        do_reset;
        step;
        fetch(32'h44440000);
        step;
        branch_taken = 1'b1; branch_addr = 32'h103;
        step;
        branch_taken = 1'b0; branch_addr = '0;
        total++; if (valid !== 1'b0 || instruction !== 32'h0 || pc_out !== 32'h0) begin bad++; $display("FAIL bw_flush got=%0h/%h/%h want=0/0/0", valid, instruction, pc_out); end
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin bad++; $display("FAIL bw_drop_req got=%0h/%h want=1/4", imem_req, imem_addr); end
        step;
        imem_ack = 1'b1; imem_rdata = 32'hDEADBEEF;
        step;
        imem_ack = 1'b0; imem_rdata = '0;
        total++; if (valid !== 1'b0 || imem_req !== 1'b0) begin bad++; $display("FAIL bw_discard got=%0h/%0h want=0/0", valid, imem_req); end
        step;
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin bad++; $display("FAIL bw_target got=%0h/%h want=1/100", imem_req, imem_addr); end
        fetch(32'h55550100);
        total++; if (valid !== 1'b1 || instruction !== 32'h55550100 || pc_out !== 32'h104) begin bad++; $display("FAIL bw_out got=%0h/%h/%h want=1/55550100/104", valid, instruction, pc_out); end
    endtask

    task automatic test_branch_ack_freeze;
        do_reset;
        step;
        fetch(32'h66660000);
        freeze = 1'b1;
        step;
        branch_taken = 1'b1; branch_addr = 32'h200; imem_ack = 1'b1; imem_rdata = 32'hBAADF00D;
        step;
        branch_taken = 1'b0; branch_addr = '0; imem_ack = 1'b0; imem_rdata = '0;
        total++; if (valid !== 1'b0 || instruction !== 32'h0 || pc_out !== 32'h0) begin bad++; $display("FAIL baf_flush got=%0h/%h/%h want=0/0/0", valid, instruction, pc_out); end
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL baf_idle got=%0h want=0", imem_req); end
        freeze = 1'b0;
        step;
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h200 || valid !== 1'b0) begin bad++; $display("FAIL baf_target got=%0h/%h/%0h want=1/200/0", imem_req, imem_addr, valid); end
        fetch(32'h77770200);
        total++; if (valid !== 1'b1 || pc_out !== 32'h204) begin bad++; $display("FAIL baf_out got=%0h/%h want=1/204", valid, pc_out); end
    endtask

    task automatic test_wrap;
        do_reset;
        step;
        branch_taken = 1'b1; branch_addr = 32'hFFFFFFFF;
        step;
        branch_taken = 1'b0; branch_addr = '0;
        imem_ack = 1'b1; imem_rdata = 32'h12345678;
        step;
        imem_ack = 1'b0; imem_rdata = '0;
        step;
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFFFFFC) begin bad++; $display("FAIL wrap_req got=%0h/%h want=1/fffffffc", imem_req, imem_addr); end
        fetch(32'h88880FFC);
        total++; if (valid !== 1'b1 || pc_out !== 32'h0 || instruction !== 32'h88880FFC) begin bad++; $display("FAIL wrap_out got=%0h/%h/%h want=1/0/88880ffc", valid, pc_out, instruction); end
        total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL wrap_next got=%h want=0", imem_addr); end
    endtask

    task automatic test_reset_mid;
        do_reset;
        step; step;
        rst = 1'b0;
        step;
        total++; if (imem_req !== 1'b0 || imem_addr !== 32'h0 || valid !== 1'b0) begin bad++; $display("FAIL rm_reset got=%0h/%h/%0h want=0/0/0", imem_req, imem_addr, valid); end
        rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hBAD0BAD0;
        step;
        imem_ack = 1'b0; imem_rdata = '0;
        total++; if (valid !== 1'b0 || instruction !== 32'h0 || pc_out !== 32'h0) begin bad++; $display("FAIL rm_ack_ignored got=%0h/%h/%h want=0/0/0", valid, instruction, pc_out); end
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin bad++; $display("FAIL rm_first_req got=%0h/%h want=1/0", imem_req, imem_addr); end
        fetch(32'h99990000);
        total++; if (valid !== 1'b1 || pc_out !== 32'h4 || instruction !== 32'h99990000) begin bad++; $display("FAIL rm_fetch got=%0h/%h/%h want=1/4/99990000", valid, pc_out, instruction); end
    endtask

    // Model: the stream of instructions ID should see is the in-order list of non-flushed fetches;
    // the next fetch address is the last accepted address + 4, or the latest branch target.
    task automatic test_random;
        logic [63:0] q[$];
        logic        outstanding, drop, quiet;
        logic [31:0] exp_addr, req_addr;
        int          cnt, lat, delivered;
        do_reset;
        outstanding = 1'b0; drop = 1'b0; exp_addr = 32'h0; req_addr = 32'h0;
        cnt = 0; lat = 1; delivered = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            if (outstanding && !imem_req) begin
                total++; bad++; $display("FAIL rnd_req_lost cyc=%0d got=0 want=1", cyc);
            end
            if (imem_req && !outstanding) begin
                total++; if (imem_addr !== exp_addr) begin bad++; $display("FAIL rnd_req_addr cyc=%0d got=%h want=%h", cyc, imem_addr, exp_addr); end
                total++; if (q.size() > 1) begin bad++; $display("FAIL rnd_req_while_full cyc=%0d got=%0d want<=1", cyc, q.size()); end
                outstanding = 1'b1; req_addr = imem_addr; cnt = 0; lat = $urandom_range(1, 3);
            end else if (outstanding) begin
                cnt++;
                total++; if (imem_addr !== req_addr) begin bad++; $display("FAIL rnd_addr_stable cyc=%0d got=%h want=%h", cyc, imem_addr, req_addr); end
            end
            total++; if (valid !== (q.size() != 0)) begin bad++; $display("FAIL rnd_valid cyc=%0d got=%0h want=%0h", cyc, valid, q.size() != 0); end
            if (q.size() != 0) begin
                total++; if ({instruction, pc_out} !== q[0]) begin bad++; $display("FAIL rnd_out cyc=%0d got=%h/%h want=%h/%h", cyc, instruction, pc_out, q[0][63:32], q[0][31:0]); end
            end

            quiet = (cyc >= 3700);
            if (quiet) freeze = 1'b0;
            else if ($urandom_range(0, 3) == 0) freeze = ~freeze;
            branch_taken = !quiet && ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 3) == 0) branch_addr = 32'hFFFFFFF0 | $urandom_range(0, 15);
            else branch_addr = $urandom_range(0, 1023);
            imem_ack   = outstanding && (cnt >= lat);
            imem_rdata = imem_ack ? mem_word(req_addr) : $urandom;

            if (branch_taken) begin
                q.delete();
                exp_addr = {branch_addr[31:2], 2'b00};
                if (imem_ack) begin outstanding = 1'b0; drop = 1'b0; end
                else if (outstanding) drop = 1'b1;
            end else begin
                if (q.size() != 0 && !freeze) begin
                    void'(q.pop_front());
                    delivered++;
                end
                if (imem_ack) begin
                    outstanding = 1'b0;
                    if (!drop) begin
                        q.push_back({mem_word(req_addr), req_addr + 32'd4});
                        exp_addr = req_addr + 32'd4;
                    end
                    drop = 1'b0;
                end
            end
        end
        @(negedge clk);
        freeze = 1'b0; branch_taken = 1'b0; imem_ack = 1'b0;
        total++; if (delivered < 200) begin bad++; $display("FAIL rnd_progress got=%0d want>=200", delivered); end
    endtask

    initial begin
        rst = 1'b0; freeze = 1'b0; branch_taken = 1'b0; branch_addr = '0;
        imem_ack = 1'b0; imem_rdata = '0;
        test_reset;
        test_first_fetch;
        test_latency;
        test_freeze;
        test_branch_wait;
        test_branch_ack_freeze;
        test_wrap;
        test_reset_mid;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage plus IF/ID pipeline register of the 5-stage ARM pipeline. It holds the PC, fetches instructions over a variable-latency req/ack instruction-memory handshake, and presents {pc_out, instruction, valid} to the ID stage. It consumes the hazard unit's stall signal (freeze) and the EXE stage's branch redirect (branch_taken/branch_addr). A one-entry skid buffer absorbs a fetch that returns while the stage is frozen.

Parameters:
ADDR_WIDTH, 32, PC / memory address width
DATA_WIDTH, 32, instruction width
RESET_PC, 0, PC value loaded at reset (word aligned)

Ports:
clk  in  1  single clock; all state updates on rising edge
rst  in  1  reset, synchronous, active-low
freeze  in  1  stall from hazard detection; hold IF/ID outputs
branch_taken  in  1  redirect/flush request from EXE
branch_addr  in  ADDR_WIDTH  redirect target; bits [1:0] ignored (treated as 0)
imem_req  out  1  fetch request, registered
imem_addr  out  ADDR_WIDTH  fetch address, stable while imem_req=1
imem_ack  in  1  one-cycle pulse: imem_rdata valid for the current request
imem_rdata  in  DATA_WIDTH  fetched instruction
pc_out  out  ADDR_WIDTH  address of presented instruction + 4
instruction  out  DATA_WIDTH  instruction to ID
valid  out  1  instruction/pc_out hold a live instruction

Behaviour:
- Reset (rst=0 at edge): pc=RESET_PC; FSM=IDLE; imem_req=0, imem_addr=0; pc_out=0, instruction=0, valid=0; skid empty. Reset mid-request abandons the request; a later imem_ack arriving in IDLE is ignored.
- FSM states: IDLE, WAIT, DROP.
- IDLE: if skid empty and no branch this cycle -> WAIT next cycle with imem_req=1, imem_addr=pc. If skid full -> stay IDLE.
- WAIT: imem_req=1, imem_addr constant until ack. imem_ack is legal from the cycle after imem_req first rises; any later cycle is also legal.
  - On ack with no branch: pc<=pc+4.
  - If freeze=0 or valid=0, load the output register: instruction<=imem_rdata, pc_out<=pc+4, valid<=1.
  - Otherwise (freeze=1 and valid=1), write the skid buffer.
  - Next state: WAIT with imem_addr=pc+4 if the skid is still empty after this cycle; else IDLE.
- Output register, no branch:
  - freeze=1: hold all three outputs.
  - freeze=0, skid full: load from skid; skid becomes empty.
  - freeze=0, skid empty, no ack: valid<=0; instruction and pc_out keep their last values.
- Skid is one entry. The skid never overflows because no request is issued while it is full.
- Back-to-back throughput with 1-cycle memory: one instruction every 2 cycles (req cycle, ack cycle).
- Branch (branch_taken=1) has priority over freeze and ack:
  - pc<={branch_addr[ADDR_WIDTH-1:2],2'b00}.
  - valid<=0, instruction<=0, pc_out<=0; skid cleared.
  - In WAIT without ack -> DROP, keeping imem_req=1 and the old address until ack, then discarding the data.
  - In WAIT with ack the same cycle -> data discarded, go IDLE.
  - In IDLE or DROP -> stay in or go to IDLE / stay DROP respectively.
- DROP: on ack -> IDLE, data discarded, pc unchanged. A second branch_taken in DROP updates pc only.
- PC arithmetic wraps modulo 2^ADDR_WIDTH (pc=FFFFFFFC -> 0).
- After a branch, the first fetch is to the target. Its output has pc_out=target+4.

Test Plan:
- Reset/first fetch, ack 1 cycle after req -> imem_addr=0, then instruction=rdata, pc_out=4, valid=1; next req addr=4.
- Ack latency 3 cycles, data 0xE3A01005 -> imem_req held 3 cycles with imem_addr=0 stable; one capture; valid low between instructions.
- Freeze=1 for 4 cycles while fetch of addr 8 returns -> outputs hold addr-4 instruction, skid holds addr-8 instruction, no new imem_req; freeze drops -> addr-8 instruction appears with pc_out=12, next req addr=12.
- branch_taken, branch_addr=0x103 while WAIT (ack 2 cycles later) -> valid=0 next cycle, stale data discarded in DROP, next req addr=0x100, output pc_out=0x104.
- branch_taken and imem_ack and freeze in the same cycle -> data discarded, skid empty, valid=0, next req addr=branch target.
- rst=0 asserted while WAIT, then ack pulse -> ack ignored, outputs zero, first request after release addr=RESET_PC.
